// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared types and defaults for the ID/EX operand stage
package ex_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RA_W_DEF = 5;

  typedef enum logic [2:0] {
    ALU_ADD      = 3'b000,
    ALU_SUB      = 3'b001,
    ALU_AND      = 3'b010,
    ALU_OR       = 3'b011,
    ALU_SLT_MASK = 3'b100,
    ALU_SLT      = 3'b101
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_REG,
    FWD_MEM,
    FWD_WB
  } fwd_sel_t;

endpackage

// File: rtl/ex_fwd_mux.sv
// rtl/ex_fwd_mux.sv - per-operand forwarding select (MEM over WB over held value)
module ex_fwd_mux
  import ex_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RA_W = RA_W_DEF
) (
  input  logic [RA_W-1:0] rs_addr,
  input  logic [XLEN-1:0] held_data,
  input  logic [RA_W-1:0] mem_rd_addr,
  input  logic            mem_reg_write,
  input  logic            mem_is_load,
  input  logic [XLEN-1:0] mem_result,
  input  logic [RA_W-1:0] wb_rd_addr,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] fwd_data,
  output fwd_sel_t        fwd_sel,
  output logic            hazard
);

  always_comb begin
    fwd_data = held_data;
    fwd_sel  = FWD_REG;
    hazard   = 1'b0;
    // x0 is hardwired, so it never takes a bypass
    if (rs_addr != '0 && mem_reg_write && mem_rd_addr == rs_addr) begin
      fwd_data = mem_result;
      fwd_sel  = FWD_MEM;
      hazard   = mem_is_load;
    end else if (rs_addr != '0 && wb_reg_write && wb_rd_addr == rs_addr) begin
      fwd_data = wb_result;
      fwd_sel  = FWD_WB;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX holding register driving ALU operands
// Optional EX_FORWARD_EN enables MEM/WB forwarding, refresh and load-use stall.
module ex_operand_stage
  import ex_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RA_W = RA_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1_addr,
  input  logic [RA_W-1:0] id_rs2_addr,
  input  logic [RA_W-1:0] id_rd_addr,
  input  logic [2:0]      id_alu_op,
  input  logic            id_alu_src,
  input  logic            id_reg_write,
  input  logic            flush,
  input  logic [RA_W-1:0] mem_rd_addr,
  input  logic [RA_W-1:0] wb_rd_addr,
  input  logic            mem_reg_write,
  input  logic            wb_reg_write,
  input  logic            mem_is_load,
  input  logic [XLEN-1:0] mem_result,
  input  logic [XLEN-1:0] wb_result,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [2:0]      ex_alu_op,
  output logic [XLEN-1:0] ex_store_data,
  output logic [RA_W-1:0] ex_rd_addr,
  output logic            ex_reg_write,
  output logic            load_use_stall
);

  logic            v;
  logic [XLEN-1:0] rs1_q, rs2_q, imm_q;
  logic [RA_W-1:0] rs1_addr_q, rs2_addr_q, rd_q;
  alu_op_t         op_q;
  logic            alu_src_q, reg_write_q;

  logic [XLEN-1:0] fwd_rs1, fwd_rs2;
  logic            accept;

`ifdef EX_FORWARD_EN
  fwd_sel_t rs1_sel, rs2_sel;
  logic     rs1_hz, rs2_hz;
  logic     unused_sel;

  ex_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
    .rs_addr(rs1_addr_q), .held_data(rs1_q),
    .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write),
    .mem_is_load(mem_is_load), .mem_result(mem_result),
    .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .fwd_data(fwd_rs1), .fwd_sel(rs1_sel), .hazard(rs1_hz)
  );

  ex_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
    .rs_addr(rs2_addr_q), .held_data(rs2_q),
    .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write),
    .mem_is_load(mem_is_load), .mem_result(mem_result),
    .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .fwd_data(fwd_rs2), .fwd_sel(rs2_sel), .hazard(rs2_hz)
  );

  assign load_use_stall = v & (rs1_hz | rs2_hz);
  assign unused_sel     = ^{rs1_sel, rs2_sel};
`else
  logic unused_fwd;

  // Decode schedules bubbles instead, so the bypass inputs are dead here
  assign fwd_rs1        = rs1_q;
  assign fwd_rs2        = rs2_q;
  assign load_use_stall = 1'b0;
  assign unused_fwd     = ^{mem_rd_addr, wb_rd_addr, mem_reg_write, wb_reg_write,
                            mem_is_load, mem_result, wb_result, rs1_addr_q, rs2_addr_q};
`endif

  assign ex_valid = v & ~load_use_stall;
  assign in_ready = ~v | (ex_ready & ex_valid);
  assign accept   = in_valid & in_ready;

  assign ex_a          = fwd_rs1;
  assign ex_b          = alu_src_q ? imm_q : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign ex_alu_op     = op_q;
  assign ex_rd_addr    = rd_q;
  assign ex_reg_write  = reg_write_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v           <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_q        <= '0;
      op_q        <= ALU_ADD;
      alu_src_q   <= 1'b0;
      reg_write_q <= 1'b0;
    end else if (flush) begin
      v <= 1'b0;
    end else if (accept) begin
      v           <= 1'b1;
      rs1_q       <= id_rs1_data;
      rs2_q       <= id_rs2_data;
      imm_q       <= id_imm;
      rs1_addr_q  <= id_rs1_addr;
      rs2_addr_q  <= id_rs2_addr;
      rd_q        <= id_rd_addr;
      op_q        <= alu_op_t'(id_alu_op);
      alu_src_q   <= id_alu_src;
      reg_write_q <= id_reg_write;
    end else begin
      if (ex_ready && ex_valid) v <= 1'b0;
      // Capture bypassed values so a WB result retiring mid-stall is kept
      if (v) begin
        rs1_q <= fwd_rs1;
        rs2_q <= fwd_rs2;
      end
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - randomized self-checking bench for ex_operand_stage
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [2:0]  id_alu_op;
  logic        id_alu_src, id_reg_write, flush;
  logic [4:0]  mem_rd_addr, wb_rd_addr;
  logic        mem_reg_write, wb_reg_write, mem_is_load;
  logic [31:0] mem_result, wb_result;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_a, ex_b, ex_store_data;
  logic [2:0]  ex_alu_op;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write, load_use_stall;

  int passed = 0;
  int total  = 0;

  // reference model of the single held instruction
  logic        m_v;
  logic [31:0] m_rs1, m_rs2, m_imm;
  logic [4:0]  m_a1, m_a2, m_rd;
  logic [2:0]  m_op;
  logic        m_src, m_rw;

  ex_operand_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
    .flush(flush), .mem_rd_addr(mem_rd_addr), .wb_rd_addr(wb_rd_addr),
    .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .mem_is_load(mem_is_load), .mem_result(mem_result), .wb_result(wb_result),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_a(ex_a), .ex_b(ex_b),
    .ex_alu_op(ex_alu_op), .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] held);
`ifdef EX_FORWARD_EN
    if (a != 0 && mem_reg_write && mem_rd_addr == a) return mem_result;
    if (a != 0 && wb_reg_write && wb_rd_addr == a) return wb_result;
`endif
    return held;
  endfunction

  function automatic logic haz(input logic [4:0] a);
`ifdef EX_FORWARD_EN
    return a != 0 && mem_reg_write && mem_rd_addr == a && mem_is_load;
`else
    return a != a;
`endif
  endfunction

  task automatic set_idle();
    in_valid = 0; flush = 0; ex_ready = 0;
    mem_reg_write = 0; wb_reg_write = 0; mem_is_load = 0;
    mem_rd_addr = 0; wb_rd_addr = 0; mem_result = 0; wb_result = 0;
  endtask

  task automatic set_instr(input logic [4:0] a1, input logic [31:0] d1, input logic [4:0] a2,
                           input logic [31:0] d2, input logic [31:0] imm, input logic src,
                           input logic [2:0] op);
    id_rs1_addr = a1; id_rs1_data = d1; id_rs2_addr = a2; id_rs2_data = d2;
    id_imm = imm; id_alu_src = src; id_alu_op = op;
    id_rd_addr = 5'd9; id_reg_write = 1;
  endtask

  // Check combinational outputs mid-cycle, then advance the model across the edge
  task automatic cycle();
    logic [31:0] fa, fb;
    logic        stall, ev, ir;
    @(negedge clk);
    fa    = fwd(m_a1, m_rs1);
    fb    = fwd(m_a2, m_rs2);
    stall = m_v & (haz(m_a1) | haz(m_a2));
    ev    = m_v & ~stall;
    ir    = ~m_v | (ex_ready & ev);
    check("in_ready", 32'(in_ready), 32'(ir));
    check("ex_valid", 32'(ex_valid), 32'(ev));
    check("load_use_stall", 32'(load_use_stall), 32'(stall));
    if (m_v) begin
      check("ex_a", ex_a, fa);
      check("ex_b", ex_b, m_src ? m_imm : fb);
      check("ex_store_data", ex_store_data, fb);
      check("ex_alu_op", 32'(ex_alu_op), 32'(m_op));
      check("ex_rd_addr", 32'(ex_rd_addr), 32'(m_rd));
      check("ex_reg_write", 32'(ex_reg_write), 32'(m_rw));
    end
    if (rst) begin
      m_v = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_a1 = 0; m_a2 = 0;
      m_rd = 0; m_op = 0; m_src = 0; m_rw = 0;
    end else if (flush) begin
      m_v = 0;
    end else if (in_valid && ir) begin
      m_v = 1; m_rs1 = id_rs1_data; m_rs2 = id_rs2_data; m_imm = id_imm;
      m_a1 = id_rs1_addr; m_a2 = id_rs2_addr; m_rd = id_rd_addr;
      m_op = id_alu_op; m_src = id_alu_src; m_rw = id_reg_write;
    end else begin
      if (m_v) begin m_rs1 = fa; m_rs2 = fb; end
      if (ex_ready && ev) m_v = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_v = 0;
    rst = 1;
    set_idle();
    set_instr(0, 0, 0, 0, 0, 0, 0);
    cycle();
    cycle();
    rst = 0;
    #2;
    check("rst in_ready", 32'(in_ready), 1);
    check("rst ex_valid", 32'(ex_valid), 0);
    check("rst stall", 32'(load_use_stall), 0);
    check("rst ex_a", ex_a, 0);
    check("rst ex_b", ex_b, 0);
    check("rst store", ex_store_data, 0);
    check("rst op/rd/rw", 32'({ex_alu_op, ex_rd_addr, ex_reg_write}), 0);

    // basic accept: one cycle to ex_valid
    set_instr(5'd3, 32'd5, 5'd2, 32'd7, 32'd0, 0, 3'b000);
    in_valid = 1;
    cycle();
    in_valid = 0;
    #2;
    check("first ex_a", ex_a, 32'd5);
    check("first ex_b", ex_b, 32'd7);
    check("first ex_valid", 32'(ex_valid), 1);

    // MEM beats WB on rs1
    mem_rd_addr = 3; mem_reg_write = 1; mem_result = 32'h11;
    wb_rd_addr = 3; wb_reg_write = 1; wb_result = 32'h22;
    cycle();
    // replace with an x0 source under the same bypass traffic
    set_instr(5'd0, 32'h55, 5'd2, 32'd7, 32'd0, 0, 3'b001);
    in_valid = 1; ex_ready = 1;
    cycle();
    in_valid = 0; ex_ready = 0;
    cycle();

    // load-use on rs2, resolved from WB next cycle
    set_idle();
    mem_rd_addr = 2; mem_reg_write = 1; mem_is_load = 1; mem_result = 32'hdead;
    ex_ready = 1;
    cycle();
    set_idle();
    ex_ready = 1;
    wb_rd_addr = 2; wb_reg_write = 1; wb_result = 32'h99;
    cycle();
    set_idle();

    // WB value seen once during a 3-cycle hold persists
    set_instr(5'd4, 32'h1, 5'd5, 32'h2, 32'd0, 0, 3'b010);
    in_valid = 1;
    cycle();
    in_valid = 0;
    wb_rd_addr = 4; wb_reg_write = 1; wb_result = 32'h44;
    cycle();
    wb_reg_write = 0; wb_result = 32'h0;
    cycle();
    cycle();
    ex_ready = 1;
    cycle();
    ex_ready = 0;

    // flush wins over accept
    set_instr(5'd6, 32'h66, 5'd7, 32'h77, 32'd0, 0, 3'b011);
    in_valid = 1; flush = 1;
    cycle();
    in_valid = 0; flush = 0;
    cycle();

    // immediate on B, store data keeps forwarded rs2
    set_instr(5'd1, 32'h3, 5'd2, 32'h4, 32'hFFFFFFFC, 1, 3'b000);
    in_valid = 1;
    cycle();
    in_valid = 0;
    mem_rd_addr = 2; mem_reg_write = 1; mem_result = 32'h8;
    cycle();
    set_idle();
    ex_ready = 1;
    cycle();

    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 199) == 0);
      flush         = ($urandom_range(0, 19) == 0);
      in_valid      = $urandom_range(0, 1) == 1;
      ex_ready      = $urandom_range(0, 4) < 3;
      set_instr(5'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 3)), $urandom,
                $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 5)));
      id_rd_addr    = 5'($urandom_range(0, 31));
      id_reg_write  = 1'($urandom_range(0, 1));
      mem_rd_addr   = 5'($urandom_range(0, 3));
      wb_rd_addr    = 5'($urandom_range(0, 3));
      mem_reg_write = 1'($urandom_range(0, 1));
      wb_reg_write  = 1'($urandom_range(0, 1));
      mem_is_load   = ($urandom_range(0, 3) == 0);
      mem_result    = $urandom;
      wb_result     = $urandom;
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
